lsu_mem_stage: RTL and testbench

- Load/store unit in the MEM stage, directly downstream of the EX-stage ALU; takes ALUResult as the effective byte address.
- Formats store data and byte enables.
- Runs a request/acknowledge handshake with data memory.
- Aligns and sign- or zero-extends load data for writeback.
- Stalls the pipeline while a memory access is outstanding; flags misaligned or illegal accesses instead of issuing them.

---
 rtl/lsu_mem_stage.sv | 158 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: formats store data and byte enables, runs the
// req/ack handshake with data memory, and aligns/extends load data.
module lsu_mem_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic                  stall,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // state  | meaning
   // IDLE   | ready for a new request from EX
   // ACCESS | memory request outstanding, waiting for mem_ack
   // RESP   | one-cycle completion pulse (data or error)
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]            state;
   logic [2:0]            lat_f3;
   logic [1:0]            lat_off;
   logic                  lat_we;

   logic                  ld_ok;
   logic                  st_ok;
   logic                  misal;
   logic                  req_err;
   logic [3:0]            be_fmt;
   logic [DATA_WIDTH-1:0] wdata_fmt;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [DATA_WIDTH-1:0] load_fmt;

   assign req_ready = (state == S_IDLE);
   assign stall     = ((state == S_IDLE) & req_valid) | (state == S_ACCESS);

   always_comb begin
      ld_ok = 1'b0;
      st_ok = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: begin
            ld_ok = 1'b1;
            st_ok = 1'b1;
         end
         3'b100, 3'b101: ld_ok = 1'b1;
         default: ;
      endcase
      misal   = ((req_funct3[1:0] == 2'b01) & ALUResult[0]) |
                ((req_funct3[1:0] == 2'b10) & (ALUResult[1:0] != 2'b00));
      req_err = ~(req_we ? st_ok : ld_ok) | misal;
   end

   always_comb begin
      be_fmt    = 4'b1111;
      wdata_fmt = store_data;
      if (req_we) begin
         case (req_funct3[1:0])
            2'b00: begin
               be_fmt    = 4'b0001 << ALUResult[1:0];
               wdata_fmt = {4{store_data[7:0]}};
            end
            2'b01: begin
               be_fmt    = 4'b0011 << {ALUResult[1], 1'b0};
               wdata_fmt = {2{store_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // lane select uses the captured offset; mem_rdata is only valid with mem_ack
   always_comb begin
      byte_sel = mem_rdata[{lat_off, 3'b000} +: 8];
      half_sel = mem_rdata[{lat_off[1], 4'b0000} +: 16];
      case (lat_f3)
         3'b000:  load_fmt = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         3'b001:  load_fmt = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: load_fmt = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         lat_f3     <= 3'b000;
         lat_off    <= 2'b00;
         lat_we     <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= 4'b0000;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lat_f3  <= req_funct3;
                  lat_off <= ALUResult[1:0];
                  lat_we  <= req_we;
                  if (req_err) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state     <= S_ACCESS;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                     mem_be    <= be_fmt;
                     mem_wdata <= req_we ? wdata_fmt : '0;
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ack) begin
                  state      <= S_RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= lat_we ? '0 : load_fmt;
               end
            end
            S_RESP: begin
               state      <= S_IDLE;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed scenarios plus random transactions checked
// against an arithmetic reference model of the load/store rules.
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] ALUResult = '0;
   logic [31:0] store_data = '0;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lsu_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .ALUResult(ALUResult), .store_data(store_data),
      .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // ---- reference model ----
   function automatic bit m_err(input bit we, input bit [2:0] f3, input bit [31:0] a);
      int sz;
      bit legal;
      sz = f3 % 4;
      if (we) legal = (f3 <= 2);
      else    legal = (f3 <= 2) || (f3 == 4) || (f3 == 5);
      if (sz == 1 && (a % 2) != 0) return 1'b1;
      if (sz == 2 && (a % 4) != 0) return 1'b1;
      return !legal;
   endfunction

   function automatic bit [3:0] m_be(input bit we, input bit [2:0] f3, input bit [31:0] a);
      if (!we) return 4'hF;
      case (f3 % 4)
         0:       return 4'(1 << (a % 4));
         1:       return 4'(3 << (a % 4));
         default: return 4'hF;
      endcase
   endfunction

   function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] sd);
      case (f3 % 4)
         0:       return (sd % 256) * 32'h0101_0101;
         1:       return (sd % 65536) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   function automatic bit [31:0] m_rdata(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
      bit [31:0] sh;
      bit [31:0] v;
      sh = rd >> (8 * (a % 4));
      case (f3)
         0: begin v = sh % 256;   if (v >= 128)   v = v - 256;   end
         1: begin v = sh % 65536; if (v >= 32768) v = v - 65536; end
         4: v = sh % 256;
         5: v = sh % 65536;
         default: v = rd;
      endcase
      return v;
   endfunction

   // Presents one request at the current point (just after a falling edge)
   // and follows it through to the IDLE cycle after its response.
   task automatic do_txn(input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] sd, input bit [31:0] rd, input int dly,
                         input bit hold);
      bit        e_err;
      bit [3:0]  e_be;
      bit [31:0] e_wd;
      bit [31:0] e_rd;
      e_err = m_err(we, f3, a);
      e_be  = m_be(we, f3, a);
      e_wd  = m_wdata(f3, sd);
      e_rd  = we ? 32'h0 : m_rdata(f3, a, rd);

      req_valid = 1'b1; req_we = we; req_funct3 = f3; ALUResult = a; store_data = sd;
      mem_ack = 1'b0;
      #1;
      n_cmp++;
      if (req_ready !== 1'b1 || stall !== 1'b1) begin
         n_bad++;
         $display("FAIL accept f3=%0d a=%h: ready=%b stall=%b, required 1 1", f3, a, req_ready, stall);
      end
      @(negedge clk);
      if (hold) begin
         req_we = 1'b0; req_funct3 = 3'b010; ALUResult = 32'h0000_0400;
      end else begin
         req_valid = 1'b0;
      end
      #1;
      if (e_err) begin
         n_cmp++;
         if ({resp_valid, resp_err, mem_req, stall, req_ready} !== 5'b11000) begin
            n_bad++;
            $display("FAIL err_resp f3=%0d a=%h: valid/err/req/stall/ready=%b%b%b%b%b, required 11000",
                     f3, a, resp_valid, resp_err, mem_req, stall, req_ready);
         end
      end else begin
         for (int i = 0; i <= dly; i++) begin
            mem_ack   = (i == dly);
            mem_rdata = (i == dly) ? rd : $urandom;
            #1;
            n_cmp++;
            if ({mem_req, mem_we, mem_addr, mem_be, stall, req_ready} !==
                {1'b1, we, a & 32'hFFFF_FFFC, e_be, 1'b1, 1'b0}) begin
               n_bad++;
               $display("FAIL access c%0d: req=%b we=%b addr=%h be=%b stall=%b ready=%b, required 1 %b %h %b 1 0",
                        i, mem_req, mem_we, mem_addr, mem_be, stall, req_ready, we, a & 32'hFFFF_FFFC, e_be);
            end
            if (we) begin
               n_cmp++;
               if (mem_wdata !== e_wd) begin
                  n_bad++;
                  $display("FAIL wdata f3=%0d sd=%h: got %h, required %h", f3, sd, mem_wdata, e_wd);
               end
            end
            @(negedge clk);
         end
         mem_ack = 1'b0; mem_rdata = $urandom;
         #1;
         n_cmp++;
         if ({resp_valid, resp_err, mem_req, stall} !== 4'b1000 || resp_rdata !== e_rd) begin
            n_bad++;
            $display("FAIL resp f3=%0d a=%h: valid/err/req/stall=%b%b%b%b rdata=%h, required 1000 %h",
                     f3, a, resp_valid, resp_err, mem_req, stall, resp_rdata, e_rd);
         end
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({resp_valid, mem_req, req_ready} !== 3'b001) begin
         n_bad++;
         $display("FAIL post_resp: valid/req/ready=%b%b%b, required 001", resp_valid, mem_req, req_ready);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, resp_valid, resp_rdata, resp_err} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h be=%b rv=%b rd=%h err=%b, required all 0",
                  mem_req, mem_we, mem_addr, mem_wdata, mem_be, resp_valid, resp_rdata, resp_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || stall !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: ready=%b stall=%b, required 1 0", req_ready, stall);
      end
   endtask

   task automatic test_loads;
      do_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 1'b0);
      do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 1, 1'b0);
      do_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 0, 1'b0);
      do_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 2, 1'b0);
   endtask

   task automatic test_stores;
      do_txn(1'b1, 3'b000, 32'h202, 32'h1234_56AB, 32'h0, 0, 1'b0);
      do_txn(1'b1, 3'b001, 32'h202, 32'h1234_56AB, 32'h0, 1, 1'b0);
      do_txn(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
   endtask

   task automatic test_errors;
      do_txn(1'b1, 3'b010, 32'h301, 32'h1, 32'h0, 0, 1'b0);
      do_txn(1'b0, 3'b001, 32'h301, 32'h0, 32'h0, 0, 1'b0);
      do_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0);
      do_txn(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1'b0);
   endtask

   task automatic test_ack_delay;
      do_txn(1'b0, 3'b010, 32'h600, 32'h0, 32'h1357_9BDF, 5, 1'b1);
      // the held second request is accepted in this IDLE cycle
      do_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h2468_ACE0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_access;
      bit seen;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; ALUResult = 32'h500;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_pre: mem_req=%b, required 1", mem_req);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_async: mem_req=%b resp_valid=%b, required 0 0", mem_req, resp_valid);
      end
      @(negedge clk);
      rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid !== 1'b0 || mem_req !== 1'b0) seen = 1'b1;
      end
      mem_ack = 1'b0;
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL stray_ack: response or request seen %b, required 0", seen);
      end
      do_txn(1'b0, 3'b010, 32'h504, 32'h0, 32'h0BAD_F00D, 1, 1'b0);
   endtask

   task automatic test_random;
      bit [31:0] a;
      for (int n = 0; n < 60; n++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
         do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                $urandom, $urandom, $urandom_range(0, 3), 1'b0);
      end
   endtask

   initial begin
      test_reset;
      test_loads;
      test_stores;
      test_errors;
      test_ack_delay;
      test_reset_mid_access;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
